// File: rtl/css_window_mac.sv
// ============================================================================
// Module      : css_window_mac
// Description : 3x3 window dot-product and multi-channel accumulator, valid/ready out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module css_window_mac #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int KERNEL_SIZE        = 3
) (
  input  logic                            clk,
  input  logic                            arst_in,
  input  logic [9*IO_DATA_WIDTH-1:0]      win_data,
  input  logic [9*IO_DATA_WIDTH-1:0]      weight_data,
  input  logic                            win_valid,
  output logic                            win_ready,
  output logic [ACCUMULATION_WIDTH-1:0]   out_data,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int c_nb_taps = 9;
  localparam int c_cnt_w   = (INPUT_NB_CHANNELS > 1) ? $clog2(INPUT_NB_CHANNELS) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(INPUT_NB_CHANNELS - 1);

  if (KERNEL_SIZE != 3) begin : g_bad_kernel
    $error("css_window_mac: KERNEL_SIZE must be 3");
  end
  if (INPUT_NB_CHANNELS < 1) begin : g_bad_channels
    $error("css_window_mac: INPUT_NB_CHANNELS must be >= 1");
  end

  logic                                        en;
  logic                                        xfer;
  logic                                        beat_last;
  logic [ACCUMULATION_WIDTH-1:0]               acc_sum;
  logic [ACCUMULATION_WIDTH-1:0]               sum_all;
  logic [c_nb_taps-1:0][ACCUMULATION_WIDTH-1:0] prod_w;

  logic [c_cnt_w-1:0]                          cnt_q, cnt_d;
  logic                                        s1_valid_q, s1_valid_d;
  logic                                        s1_last_q, s1_last_d;
  logic [c_nb_taps-1:0][ACCUMULATION_WIDTH-1:0] prod_q, prod_d;
  logic                                        s2_valid_q, s2_valid_d;
  logic                                        s2_last_q, s2_last_d;
  logic [ACCUMULATION_WIDTH-1:0]               sum_q, sum_d;
  logic [ACCUMULATION_WIDTH-1:0]               acc_q, acc_d;
  logic [ACCUMULATION_WIDTH-1:0]               out_data_q, out_data_d;
  logic                                        out_valid_q, out_valid_d;

  // Taps and weights are sign-extended before multiplying so the product wraps at accumulator width.
  for (genvar k = 0; k < c_nb_taps; k++) begin : g_tap
    logic signed [IO_DATA_WIDTH-1:0]      tap;
    logic signed [IO_DATA_WIDTH-1:0]      wt;
    logic signed [ACCUMULATION_WIDTH-1:0] prod;
    assign tap       = win_data[k*IO_DATA_WIDTH +: IO_DATA_WIDTH];
    assign wt        = weight_data[k*IO_DATA_WIDTH +: IO_DATA_WIDTH];
    assign prod      = ACCUMULATION_WIDTH'(tap) * ACCUMULATION_WIDTH'(wt);
    assign prod_w[k] = prod;
  end

  always_comb begin
    en        = !out_valid_q || out_ready;
    xfer      = win_valid && en;
    beat_last = (cnt_q == c_last_cnt);

    sum_all = '0;
    for (int k = 0; k < c_nb_taps; k++) begin
      sum_all = sum_all + prod_q[k];
    end
    acc_sum = acc_q + sum_q;

    cnt_d       = cnt_q;
    s1_valid_d  = s1_valid_q;
    s1_last_d   = s1_last_q;
    prod_d      = prod_q;
    s2_valid_d  = s2_valid_q;
    s2_last_d   = s2_last_q;
    sum_d       = sum_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;

    if (xfer) begin
      cnt_d = beat_last ? '0 : cnt_q + 1'b1;
    end

    if (en) begin
      s1_valid_d = xfer;
      s1_last_d  = xfer && beat_last;
      prod_d     = prod_w;
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      sum_d      = sum_all;
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A final write in the same cycle as a handshake keeps out_valid high with fresh data.
    if (en && s2_valid_q) begin
      if (s2_last_q) begin
        out_data_d  = acc_sum;
        out_valid_d = 1'b1;
        acc_d       = '0;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      cnt_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      prod_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      sum_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      prod_q      <= prod_d;
      s2_valid_q  <= s2_valid_d;
      s2_last_q   <= s2_last_d;
      sum_q       <= sum_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign win_ready = en;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

`default_nettype wire

// File: doc/css_window_mac.md
Name: css_window_mac

Overview:
- Downstream consumer of the 3x3 column-shift window stage (the 9 window taps out_1_2..out_3_4).
- Each accepted beat is one input channel's 3x3 window plus its 9 kernel weights. The block forms the 9-tap signed dot product and accumulates it over INPUT_NB_CHANNELS consecutive beats.
- It emits one ACCUMULATION_WIDTH output-pixel partial result per group via a valid/ready handshake.
- It sits between the window shifter and the output writeback/memory interface.

Parameters:
- IO_DATA_WIDTH, 16: width of each window tap and weight; signed two's complement.
- ACCUMULATION_WIDTH, 32: width of products, sums, accumulator and output.
- INPUT_NB_CHANNELS, 64: beats accumulated per output result; must be >= 1.
- KERNEL_SIZE, 3: fixed at 3; any other value is a compile-time error.

Ports:
- clk  in  1  clock; all state on rising edge.
- arst_in  in  1  asynchronous reset, active-high.
- win_data  in  9*IO_DATA_WIDTH  window taps. Slice k=(r-1)*3+(c-2) holds tap at row r, column c (c = 2..4), LSB slice = tap 1_2.
- weight_data  in  9*IO_DATA_WIDTH  kernel weights, same slice ordering as win_data.
- win_valid  in  1  win_data/weight_data hold a beat.
- win_ready  out  1  block can accept a beat this cycle.
- out_data  out  ACCUMULATION_WIDTH  accumulated result, signed.
- out_valid  out  1  out_data holds a result.
- out_ready  in  1  downstream accepts out_data.

Behaviour:
- Reset (arst_in high, asynchronous):
  - All pipeline valid bits = 0; accumulator = 0; channel counter = 0.
  - out_data = 0; out_valid = 0.
  - win_ready evaluates to 1 once out_valid = 0.
  - Any partially accumulated group is discarded. No output is ever produced for a group interrupted by reset.
- Stall:
  - en = !out_valid || out_ready (combinational). win_ready = en.
  - When en = 0, every pipeline register, the counter and the accumulator hold their values.
- Accept: a beat transfers when win_valid && win_ready. win_data/weight_data are don't-care otherwise.
- Last tag:
  - Channel counter increments on every transfer and wraps from INPUT_NB_CHANNELS-1 to 0.
  - The beat transferred while counter == INPUT_NB_CHANNELS-1 carries last = 1.
  - With INPUT_NB_CHANNELS = 1, every beat is last.
- Stage S1 (registered, on en):
  - 9 signed products tap*weight, each sign-extended to ACCUMULATION_WIDTH.
  - s1_valid and s1_last are captured from the transfer.
  - A bubble (no transfer while en = 1) clears s1_valid.
- Stage S2 (registered, on en): signed sum of the 9 S1 products, truncated modulo 2^ACCUMULATION_WIDTH (wrap, no saturation). Carries s2_valid and s2_last.
- Stage S3 (accumulate, on en && s2_valid):
  - If s2_last = 0: acc <= acc + sum.
  - If s2_last = 1: out_data <= acc + sum; out_valid <= 1; acc <= 0.
  - Arithmetic wraps modulo 2^ACCUMULATION_WIDTH.
- Output handshake:
  - out_valid && out_ready clears out_valid next cycle, unless a new last result is written in the same cycle; in that case out_valid stays 1 with the new data.
  - out_data holds stable while out_valid && !out_ready.
- Latency: last beat accepted in cycle t gives out_valid = 1 in cycle t+3, absent stalls.
- Throughput: one beat per cycle with out_ready held high. Groups run back-to-back with no gap cycles.
- Simultaneous events:
  - A transfer in the same cycle as an S3 final write is legal; the new beat starts the next group's pipeline.
  - A stall freezes all in-flight beats; no beat is lost or duplicated.

Test Plan:
- Default params; 64 beats, all taps = 1, all weights = 1, out_ready = 1 -> exactly one result, out_data = 576 (0x00000240), out_valid high 3 cycles after the 64th transfer.
- 64 beats, taps = -1 (0xFFFF), weights = 2 -> out_data = -1152 (0xFFFFFB80).
- Wrap: 64 beats, taps = weights = 32767 -> out_data = 0xFDC00240 (-37748160).
- Backpressure:
  - 128 all-ones beats with out_ready = 0.
  - After the first result: win_ready = 0, and out_data holds 576 for 20 stalled cycles.
  - Release out_ready -> second result 576 appears; 2 results total, none lost.
- Reset mid-group: 10 beats of ones, pulse arst_in for 1 cycle (all outputs 0 during the pulse), then 64 beats of ones -> single result 576, not 666.
- Back-to-back groups, win_valid continuous: group A taps = 1, weights = 3 -> 1728; then group B taps = 2, weights = -1 -> -1152. Results occur in order, 64 cycles apart, with no idle cycle between groups.
